sap1_controller_sequencer: RTL and testbench

Controller-sequencer for the SAP-1 datapath. A six-state ring counter (T1–T6) is decoded with the instruction-register opcode into the 12-bit control word. That word drives the load enables (`G_bar`-style) and output enables of every SN74LS173-class register on the W bus. The block is the direct control-side neighbour of those registers: it produces every load/enable strobe they consume.

---
 rtl/sap1_pkg.sv | 59 +++++
 rtl/sap1_controller_sequencer_if.sv | 13 +
 rtl/sap1_ring_counter.sv | 28 ++
 rtl/sap1_controller_sequencer.sv | 112 +++++++++++
 tb/tb_sap1_controller_sequencer.sv | 131 +++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 controller definitions: opcodes, control-word bit positions,
// named control words and the ring-state check used by the sequencer.
package sap1_pkg;

  localparam int OPCODE_BITS = 4;
  localparam int CW_BITS     = 12;
  localparam int RING_BITS   = 6;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Bit positions inside CON[12:1]
  localparam int CW_CP     = 12;
  localparam int CW_EP     = 11;
  localparam int CW_LM_BAR = 10;
  localparam int CW_CE_BAR = 9;
  localparam int CW_LI_BAR = 8;
  localparam int CW_EI_BAR = 7;
  localparam int CW_LA_BAR = 6;
  localparam int CW_EA     = 5;
  localparam int CW_SU     = 4;
  localparam int CW_EU     = 3;
  localparam int CW_LB_BAR = 2;
  localparam int CW_LO_BAR = 1;

  localparam logic [12:1] CW_IDLE     = 12'h3E3;
  localparam logic [12:1] CW_FETCH_T1 = 12'h5E3;
  localparam logic [12:1] CW_FETCH_T2 = 12'hBE3;
  localparam logic [12:1] CW_FETCH_T3 = 12'h263;

  localparam logic [12:1] CW_LDA_T4 = 12'h1A3;
  localparam logic [12:1] CW_LDA_T5 = 12'h2C3;
  localparam logic [12:1] CW_LDA_T6 = 12'h3E3;
  localparam logic [12:1] CW_ADD_T4 = 12'h1A3;
  localparam logic [12:1] CW_ADD_T5 = 12'h2E1;
  localparam logic [12:1] CW_ADD_T6 = 12'h3C7;
  localparam logic [12:1] CW_SUB_T4 = 12'h1A3;
  localparam logic [12:1] CW_SUB_T5 = 12'h2E1;
  localparam logic [12:1] CW_SUB_T6 = 12'h3CF;
  localparam logic [12:1] CW_OUT_T4 = 12'h3F2;
  localparam logic [12:1] CW_OUT_T5 = 12'h3E3;
  localparam logic [12:1] CW_OUT_T6 = 12'h3E3;

  localparam logic [6:1] RING_T1 = 6'b000001;
  localparam logic [6:1] RING_T2 = 6'b000010;
  localparam logic [6:1] RING_T3 = 6'b000100;
  localparam logic [6:1] RING_T4 = 6'b001000;
  localparam logic [6:1] RING_T5 = 6'b010000;
  localparam logic [6:1] RING_T6 = 6'b100000;

  // True when exactly one ring bit is set
  function automatic logic ring_is_valid(input logic [6:1] t);
    return $onehot(t);
  endfunction

endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// Controller-side bus of the SAP-1 sequencer: opcode in, control word,
// ring state and halt flag out.
interface sap1_controller_sequencer_if #(
  parameter int OPCODE_WIDTH = 4
);
  logic [OPCODE_WIDTH:1] OPCODE;
  logic [12:1]           CON;
  logic [6:1]            T;
  logic                  HLT_bar;

  modport master (output OPCODE, input CON, input T, input HLT_bar);
  modport slave  (input OPCODE, output CON, output T, output HLT_bar);
endinterface

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot ring counter T1..T6 with synchronous clear and hold.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       hold,
  output logic [6:1] t
);

  logic [6:1] t_r;

  // Ring register; a corrupted (non one-hot) value falls back to T1
  always_ff @(posedge CLK) begin
    if (CLR) begin
      t_r <= RING_T1;
    end else if (!ring_is_valid(t_r)) begin
      t_r <= RING_T1;
    end else if (hold) begin
      t_r <= t_r;
    end else begin
      t_r <= {t_r[5:1], t_r[6]};
    end
  end

  assign t = t_r;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: decodes ring state and opcode into CON[12:1].
// Optional macro SAP1_CTRL_ILLEGAL_HALT_EN makes undefined opcodes halt.
module sap1_controller_sequencer
  import sap1_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                         CLK,
  input  logic                         CLR,
  sap1_controller_sequencer_if.slave   bus
);

  logic [6:1]            t_s;
  logic [OPCODE_WIDTH:1] op_s;
  logic                  is_halt_op_s;
  logic                  halt_now_s;
  logic                  hold_s;
  logic                  halted_r;
  logic                  hlt_bar_r;
  logic [12:1]           con_s;

  assign op_s = bus.OPCODE;

  // Classify the opcode as a halting instruction
  always_comb begin
    is_halt_op_s = 1'b0;
    if (op_s == OPCODE_WIDTH'(OP_HLT)) begin
      is_halt_op_s = 1'b1;
    end else begin
`ifdef SAP1_CTRL_ILLEGAL_HALT_EN
      is_halt_op_s = (op_s != OPCODE_WIDTH'(OP_LDA)) &&
                     (op_s != OPCODE_WIDTH'(OP_ADD)) &&
                     (op_s != OPCODE_WIDTH'(OP_SUB)) &&
                     (op_s != OPCODE_WIDTH'(OP_OUT));
`else
      is_halt_op_s = 1'b0;
`endif
    end
  end

  // The edge that ends T4 of a halt must already keep the ring at T4
  assign halt_now_s = t_s[4] && is_halt_op_s && !halted_r;
  assign hold_s     = halted_r || halt_now_s;

  sap1_ring_counter u_ring (
    .CLK  (CLK),
    .CLR  (CLR),
    .hold (hold_s),
    .t    (t_s)
  );

  // Halt flag and its registered active-low output
  always_ff @(posedge CLK) begin
    if (CLR) begin
      halted_r  <= 1'b0;
      hlt_bar_r <= 1'b1;
    end else if (halt_now_s) begin
      halted_r  <= 1'b1;
      hlt_bar_r <= 1'b0;
    end else begin
      halted_r  <= halted_r;
      hlt_bar_r <= hlt_bar_r;
    end
  end

  // Control-word decode from ring state and opcode
  always_comb begin
    con_s = CW_IDLE;
    if (halted_r) begin
      con_s = CW_IDLE;
    end else begin
      case (t_s)
        RING_T1: con_s = CW_FETCH_T1;
        RING_T2: con_s = CW_FETCH_T2;
        RING_T3: con_s = CW_FETCH_T3;
        RING_T4: begin
          case (op_s)
            OPCODE_WIDTH'(OP_LDA): con_s = CW_LDA_T4;
            OPCODE_WIDTH'(OP_ADD): con_s = CW_ADD_T4;
            OPCODE_WIDTH'(OP_SUB): con_s = CW_SUB_T4;
            OPCODE_WIDTH'(OP_OUT): con_s = CW_OUT_T4;
            default:               con_s = CW_IDLE;
          endcase
        end
        RING_T5: begin
          case (op_s)
            OPCODE_WIDTH'(OP_LDA): con_s = CW_LDA_T5;
            OPCODE_WIDTH'(OP_ADD): con_s = CW_ADD_T5;
            OPCODE_WIDTH'(OP_SUB): con_s = CW_SUB_T5;
            OPCODE_WIDTH'(OP_OUT): con_s = CW_OUT_T5;
            default:               con_s = CW_IDLE;
          endcase
        end
        RING_T6: begin
          case (op_s)
            OPCODE_WIDTH'(OP_LDA): con_s = CW_LDA_T6;
            OPCODE_WIDTH'(OP_ADD): con_s = CW_ADD_T6;
            OPCODE_WIDTH'(OP_SUB): con_s = CW_SUB_T6;
            OPCODE_WIDTH'(OP_OUT): con_s = CW_OUT_T6;
            default:               con_s = CW_IDLE;
          endcase
        end
        default: con_s = CW_IDLE;
      endcase
    end
  end

  assign bus.CON     = con_s;
  assign bus.T       = t_s;
  assign bus.HLT_bar = hlt_bar_r;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Self-checking bench: directed sequences plus random opcodes compared against
// a step/halt reference model built from the SAP-1 control-word table.
module tb_sap1_controller_sequencer;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  // Reference model state
  int   m_step;
  bit   m_halted;
  bit   m_valid;

  sap1_controller_sequencer_if #(.OPCODE_WIDTH(4)) bus ();

  sap1_controller_sequencer #(.OPCODE_WIDTH(4)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_halts(input logic [3:0] op);
`ifdef SAP1_CTRL_ILLEGAL_HALT_EN
    return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b1110});
`else
    return op == 4'b1111;
`endif
  endfunction

  // Control word table: fetch words, then per-instruction execute triples
  function automatic logic [11:0] model_con(input int step, input logic [3:0] op, input bit halted);
    logic [11:0] fetch [3];
    logic [11:0] exe [3];
    fetch = '{12'h5E3, 12'hBE3, 12'h263};
    if (halted) return 12'h3E3;
    if (step <= 3) return fetch[step-1];
    if (op == 4'b0000)      exe = '{12'h1A3, 12'h2C3, 12'h3E3};
    else if (op == 4'b0001) exe = '{12'h1A3, 12'h2E1, 12'h3C7};
    else if (op == 4'b0010) exe = '{12'h1A3, 12'h2E1, 12'h3CF};
    else if (op == 4'b1110) exe = '{12'h3F2, 12'h3E3, 12'h3E3};
    else                    exe = '{12'h3E3, 12'h3E3, 12'h3E3};
    return exe[step-4];
  endfunction

  function automatic int bus_drivers(input logic [12:1] con);
    return int'(con[11]) + int'(!con[9]) + int'(!con[7]) + int'(con[5]) + int'(con[3]);
  endfunction

  // One clock: apply inputs, check mid-cycle, then advance the model on the edge
  task automatic cycle(input bit clr_in, input logic [3:0] op_in, input string tag);
    clr        = clr_in;
    bus.OPCODE = op_in;
    @(negedge clk);
    if (m_valid) begin
      check_value({tag, ".T"},   32'(bus.T),       32'(6'b1 << (m_step - 1)));
      check_value({tag, ".CON"}, 32'(bus.CON),     32'(model_con(m_step, op_in, m_halted)));
      check_value({tag, ".HLT"}, 32'(bus.HLT_bar), 32'(!m_halted));
      check_value({tag, ".bus"}, 32'(bus_drivers(bus.CON) <= 1), 32'd1);
    end
    @(posedge clk);
    if (clr_in) begin
      m_step   = 1;
      m_halted = 1'b0;
      m_valid  = 1'b1;
    end else if (m_halted) begin
      m_step = m_step;
    end else if (m_step == 4 && model_halts(op_in)) begin
      m_halted = 1'b1;
    end else begin
      m_step = (m_step % 6) + 1;
    end
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_step     = 1;
    m_halted   = 1'b0;
    m_valid    = 1'b0;
    clr        = 1'b0;
    bus.OPCODE = 4'b0000;
    @(posedge clk);
    #1;

    // Reset then one full LDA plus wrap back to T1
    cycle(1'b1, 4'b0000, "rst");
    for (int i = 0; i < 7; i++) cycle(1'b0, 4'b0000, "lda");

    // SUB then ADD instructions (model is at T2 here; realign with CLR)
    cycle(1'b1, 4'b0000, "rst2");
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0010, "sub");
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0001, "add");

    // HLT freezes at T4; opcode changes afterwards are ignored
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b1111, "hlt");
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'($urandom_range(0, 15)), "halted");
    cycle(1'b1, 4'b1111, "hltclr");

    // CLR during T5 of ADD: next state is T1, no T6 word
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0001, "addclr");
    cycle(1'b1, 4'b0001, "addclr_t5");
    cycle(1'b0, 4'b0001, "addclr_t1");

    // Undefined opcode 0101
    cycle(1'b1, 4'b0101, "ill_rst");
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0101, "ill");

    // Random opcodes with occasional clears
    cycle(1'b1, 4'b0000, "rnd_rst");
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 23) == 0), 4'($urandom_range(0, 15)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
